// File: rtl/step_sequencer_pkg.sv
// Shared state encoding and default sizing for the step sequencer.
package step_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_RUN   = 2'b01;
    localparam state_t ST_PAUSE = 2'b10;
    localparam state_t ST_DONE  = 2'b11;

    localparam int DEFAULT_CNT_W    = 2;
    localparam int DEFAULT_PRESCALE = 4;
    localparam int DEFAULT_TARGET   = 3;

endpackage

// File: rtl/step_sequencer_btn_edge_detect.sv
// Button rising-edge detector with registered one-cycle rise output.
// STEP_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_s;
    logic btn_q;

`ifdef STEP_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    assign btn_s = sync[1];
`else
    assign btn_s = btn;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
            rise  <= 1'b0;
        end else begin
            btn_q <= btn_s;
            rise  <= btn_s & ~btn_q;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Push-button step sequencer: single-step or prescaled auto-run of a wrapping count.
// Build option STEP_SYNC_EN synchronizes the buttons (two extra cycles of latency).
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int TARGET   = DEFAULT_TARGET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_step,
    input  logic             mode_auto,
    output logic             step_pulse,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] TGT     = CNT_W'(TARGET);

    logic start_rise;
    logic stop_rise;
    logic step_rise;

    btn_edge_detect u_start (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_start),
        .rise (start_rise)
    );

    btn_edge_detect u_stop (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_stop),
        .rise (stop_rise)
    );

    btn_edge_detect u_step (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_step),
        .rise (step_rise)
    );

    state_t           state;
    state_t           state_n;
    logic [PS_W-1:0]  presc;
    logic [PS_W-1:0]  presc_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] count_inc;
    logic             pulse_n;
    logic             start_go;

    assign start_go  = start_rise & mode_auto;
    assign count_inc = count + 1'b1;

    // Outside RUN a stop rise has no action of its own but still masks start/step.
    always_comb begin
        state_n = state;
        presc_n = presc;
        count_n = count;
        pulse_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stop_rise) begin
                    state_n = ST_IDLE;
                end else if (start_go) begin
                    state_n = ST_RUN;
                    presc_n = '0;
                end else if (step_rise) begin
                    pulse_n = 1'b1;
                    count_n = count_inc;
                end
            end
            ST_RUN: begin
                if (presc == PS_LAST) begin
                    pulse_n = 1'b1;
                    count_n = count_inc;
                    presc_n = '0;
                    if (count_inc == TGT) begin
                        state_n = ST_DONE;
                    end else if (stop_rise) begin
                        state_n = ST_PAUSE;
                    end
                end else if (stop_rise) begin
                    state_n = ST_PAUSE;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop_rise) begin
                    state_n = ST_PAUSE;
                end else if (start_go) begin
                    state_n = ST_RUN;
                end else if (step_rise) begin
                    pulse_n = 1'b1;
                    count_n = count_inc;
                    if (count_inc == TGT) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (stop_rise) begin
                    state_n = ST_DONE;
                end else if (start_go) begin
                    state_n = ST_RUN;
                    count_n = '0;
                    presc_n = '0;
                end else if (step_rise) begin
                    pulse_n = 1'b1;
                    count_n = count_inc;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            presc      <= '0;
            count      <= '0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            count      <= count_n;
            step_pulse <= pulse_n;
            busy       <= (state_n == ST_RUN);
            done       <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer; works in both STEP_SYNC_EN builds.
module tb_step_sequencer;

`ifdef STEP_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_step;
    logic       mode_auto;
    logic       step_pulse;
    logic [1:0] count;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    step_sequencer #(
        .CNT_W    (2),
        .PRESCALE (4),
        .TARGET   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_step   (btn_step),
        .mode_auto  (mode_auto),
        .step_pulse (step_pulse),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        string name;
        int    n;
        bit    r, sa, so, se, m;
        int    chk;
        bit    p;
        int    c;
        bit    b, d;
    } row_t;

    typedef struct {
        string      name;
        bit         r, sa, so, se, m, chk;
        logic [4:0] exp;
    } cyc_t;

    row_t rows[$];
    cyc_t cyc[$];
    cyc_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // chk: 0 = no check, 1 = check after last cycle of row, 2 = check every cycle
    task automatic add(input string name, input int n, input bit r, input bit sa, input bit so,
                       input bit se, input bit m, input int chk,
                       input bit p, input int c, input bit b, input bit d);
        row_t x;
        x.name = name; x.n = n; x.r = r; x.sa = sa; x.so = so; x.se = se; x.m = m;
        x.chk = chk; x.p = p; x.c = c; x.b = b; x.d = d;
        rows.push_back(x);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got pulse=%b count=%0d busy=%b done=%b, expected pulse=%b count=%0d busy=%b done=%b",
                     name, got[4], got[3:2], got[1], got[0], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        cyc_t       e;
        logic [4:0] got;
        int         k;

        rst = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_step = 1'b0; mode_auto = 1'b0;

        //   name              n  rst sa so se m  chk  p  c  b  d
        add("reset",           3, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0);
        add("idle",            2, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0);
        add("step_edge",       1, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0);
        add("step_pulse",      1, 0, 0, 0, 1, 0, 1,   1, 1, 0, 0);
        add("step_hold",       8, 0, 0, 0, 1, 0, 2,   0, 1, 0, 0);
        add("start_manual",    4, 0, 1, 0, 0, 0, 2,   0, 1, 0, 0);
        add("release",         2, 0, 0, 0, 0, 0, 2,   0, 1, 0, 0);
        add("auto_start",      1, 0, 1, 0, 0, 1, 1,   0, 1, 0, 0);
        add("auto_run",        1, 0, 1, 0, 0, 1, 1,   0, 1, 1, 0);
        add("auto_wait1",      3, 0, 0, 0, 0, 1, 2,   0, 1, 1, 0);
        add("auto_step2",      1, 0, 0, 0, 0, 1, 1,   1, 2, 1, 0);
        add("auto_wait2",      3, 0, 0, 0, 0, 1, 2,   0, 2, 1, 0);
        add("auto_step3",      1, 0, 0, 0, 0, 1, 1,   1, 3, 0, 1);
        add("done_hold",      10, 0, 0, 0, 0, 1, 2,   0, 3, 0, 1);
        add("done_step_edge",  1, 0, 0, 0, 1, 0, 1,   0, 3, 0, 1);
        add("done_step",       1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0);
        add("wrap_idle",       2, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            add("wrap_edge",   1, 0, 0, 0, 1, 0, 1,   0, c, 0, 0);
            add("wrap_step",   1, 0, 0, 0, 0, 0, 1,   1, (c + 1) % 4, 0, 0);
        end
        add("wrap_end",        1, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0);
        add("pr_start",        1, 0, 1, 0, 0, 1, 1,   0, 0, 0, 0);
        add("pr_run",          1, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0);
        add("pr_wait1",        3, 0, 0, 0, 0, 1, 2,   0, 0, 1, 0);
        add("pr_step1",        1, 0, 0, 0, 0, 1, 1,   1, 1, 1, 0);
        add("pr_wait2",        3, 0, 0, 0, 0, 1, 2,   0, 1, 1, 0);
        add("pr_step2",        1, 0, 0, 0, 0, 1, 1,   1, 2, 1, 0);
        add("pr_stop",         1, 0, 0, 1, 0, 1, 1,   0, 2, 1, 0);
        add("pr_pause",        1, 0, 0, 0, 0, 1, 1,   0, 2, 0, 0);
        add("pr_frozen",       5, 0, 0, 0, 0, 1, 2,   0, 2, 0, 0);
        add("pr_resume",       1, 0, 1, 0, 0, 1, 1,   0, 2, 0, 0);
        add("pr_run2",         1, 0, 0, 0, 0, 1, 1,   0, 2, 1, 0);
        add("pr_wait3",        2, 0, 0, 0, 0, 1, 2,   0, 2, 1, 0);
        add("pr_step3",        1, 0, 0, 0, 0, 1, 1,   1, 3, 0, 1);
        add("sim_restart",     1, 0, 1, 0, 0, 1, 1,   0, 3, 0, 1);
        add("sim_run",         1, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0);
        add("sim_tick",        1, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0);
        add("sim_press",       1, 0, 1, 1, 1, 1, 1,   0, 0, 1, 0);
        add("sim_pause",       1, 0, 1, 1, 1, 1, 1,   0, 0, 0, 0);
        add("sim_hold",        3, 0, 1, 1, 1, 1, 2,   0, 0, 0, 0);
        add("sim_release",     2, 0, 0, 0, 0, 1, 2,   0, 0, 0, 0);
        add("ts_start",        1, 0, 1, 0, 0, 1, 1,   0, 0, 0, 0);
        add("ts_run",          1, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0);
        add("ts_stop",         1, 0, 0, 1, 0, 1, 1,   0, 0, 1, 0);
        add("ts_step",         1, 0, 0, 0, 0, 1, 1,   1, 1, 0, 0);
        add("ts_paused",       3, 0, 0, 0, 0, 1, 2,   0, 1, 0, 0);
        add("rr_start",        1, 0, 1, 0, 0, 1, 1,   0, 1, 0, 0);
        add("rr_run",          1, 0, 0, 0, 0, 1, 1,   0, 1, 1, 0);
        add("rr_wait",         2, 0, 0, 0, 0, 1, 2,   0, 1, 1, 0);
        add("rr_reset",        3, 1, 0, 0, 0, 1, 2,   0, 0, 0, 0);
        add("rr_after",        4, 0, 0, 0, 0, 1, 2,   0, 0, 0, 0);

        foreach (rows[i]) begin
            for (int j = 0; j < rows[i].n; j++) begin
                cyc_t x;
                x.name = rows[i].name;
                x.r = rows[i].r; x.sa = rows[i].sa; x.so = rows[i].so;
                x.se = rows[i].se; x.m = rows[i].m;
                x.chk = (rows[i].chk == 2) || (rows[i].chk == 1 && j == rows[i].n - 1);
                x.exp = {rows[i].p, 2'(rows[i].c), rows[i].b, rows[i].d};
                cyc.push_back(x);
            end
        end

        // Buttons lead the table by the synchronizer depth so expected outputs are build-independent.
        for (int i = 0; i < cyc.size(); i++) begin
            @(negedge clk);
            rst       = cyc[i].r;
            mode_auto = cyc[i].m;
            if (i + EXTRA < cyc.size()) begin
                btn_start = cyc[i + EXTRA].sa;
                btn_stop  = cyc[i + EXTRA].so;
                btn_step  = cyc[i + EXTRA].se;
            end else begin
                btn_start = 1'b0;
                btn_stop  = 1'b0;
                btn_step  = 1'b0;
            end
            if (cyc[i].chk) sb.push_back(cyc[i]);
            @(posedge clk);
            #1;
            if (cyc[i].chk) begin
                e   = sb.pop_front();
                got = {step_pulse, count, busy, done};
                check(e.name, got, e.exp);
            end
        end

        // Latency and pulse width of a single step, measured directly.
        @(negedge clk);
        mode_auto = 1'b0;
        btn_step  = 1'b1;
        k = 0;
        for (int t = 1; t <= 10; t++) begin
            @(posedge clk);
            #1;
            if (step_pulse === 1'b1) begin
                k = t;
                break;
            end
        end
        check("lat_cycles", 5'(k), 5'(2 + EXTRA));
        check("lat_count", {step_pulse, count, busy, done}, 5'b1_01_00);
        @(posedge clk);
        #1;
        check("lat_width", {step_pulse, count, busy, done}, 5'b0_01_00);
        @(negedge clk);
        btn_step = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("lat_settle", {step_pulse, count, busy, done}, 5'b0_01_00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
